// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory access path.
// Imported by the data-memory arbiter and its round-robin picker.
package mips_mem_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int NUM_PORTS  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
      logic [NUM_PORTS-1:0] oh;
      oh      = {NUM_PORTS{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: among unmasked requesters, favours the port
// that was not served last; a lone requester always wins.
module rr_pick2
   import mips_mem_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] mask,
   input  logic                 last,
   output logic                 win,
   output logic                 valid
);

   logic [NUM_PORTS-1:0] elig_s;

   // Winner selection over the eligible (unmasked) requesters.
   always_comb begin
      elig_s = req & ~mask;
      valid  = |elig_s;
      case (elig_s)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last;
         default: win = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU on port 0, DMA/debug on port 1) with
// a registered memory interface and a one-cycle ack per completed access.
module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] we,
   input  logic [ADDR_W-1:0]    addr0,
   input  logic [ADDR_W-1:0]    addr1,
   input  logic [DATA_W-1:0]    wdata0,
   input  logic [DATA_W-1:0]    wdata1,
   output logic [NUM_PORTS-1:0] ack,
   output logic [DATA_W-1:0]    rdata,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wd,
   input  logic [DATA_W-1:0]    mem_rd
);

   arb_state_t           state_r;
   logic                 gsel_r;
   logic                 last_r;
   logic [NUM_PORTS-1:0] mask_s;
   logic                 win_s;
   logic                 win_valid_s;
   logic                 win_we_s;
   logic [ADDR_W-1:0]    win_addr_s;
   logic [DATA_W-1:0]    win_wdata_s;

   // The port whose ack is going out may not be picked again straight away.
   always_comb begin
      if (state_r == RESP) begin
         mask_s = port_onehot(gsel_r);
      end else begin
         mask_s = {NUM_PORTS{1'b0}};
      end
   end

   rr_pick2 u_pick (
      .req   (req),
      .mask  (mask_s),
      .last  (last_r),
      .win   (win_s),
      .valid (win_valid_s)
   );

   // Operands of the port about to be granted.
   always_comb begin
      if (win_s) begin
         win_we_s    = we[1];
         win_addr_s  = addr1;
         win_wdata_s = wdata1;
      end else begin
         win_we_s    = we[0];
         win_addr_s  = addr0;
         win_wdata_s = wdata0;
      end
   end

   // Arbitration FSM; memory operands are captured on grant so a requester
   // that misbehaves during ACCESS cannot corrupt the access in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         gsel_r   <= 1'b0;
         last_r   <= 1'b1;
         ack      <= {NUM_PORTS{1'b0}};
         rdata    <= {DATA_W{1'b0}};
         mem_we   <= 1'b0;
         mem_addr <= {ADDR_W{1'b0}};
         mem_wd   <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, RESP: begin
               ack <= {NUM_PORTS{1'b0}};
               if (win_valid_s) begin
                  gsel_r   <= win_s;
                  mem_we   <= win_we_s;
                  mem_addr <= win_addr_s;
                  mem_wd   <= win_wdata_s;
                  state_r  <= ACCESS;
               end else begin
                  mem_we  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               // Read and write share this cycle, so a write returns old data.
               rdata   <= mem_rd;
               last_r  <= gsel_r;
               ack     <= port_onehot(gsel_r);
               mem_we  <= 1'b0;
               state_r <= RESP;
            end
            default: begin
               ack     <= {NUM_PORTS{1'b0}};
               mem_we  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// two-port traffic scored against a word-array memory model.
module tb_dmem_arbiter;
   import mips_mem_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic [1:0]    req     = 2'b00;
   logic [1:0]    we      = 2'b00;
   logic [AW-1:0] addr0   = '0;
   logic [AW-1:0] addr1   = '0;
   logic [DW-1:0] wdata0  = '0;
   logic [DW-1:0] wdata1  = '0;
   logic [1:0]    ack;
   logic [DW-1:0] rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   logic [DW-1:0] dmem    [0:DEPTH-1];
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   logic          preload = 1'b0;

   logic          t_we   [2];
   logic [AW-1:0] t_addr [2];
   logic [DW-1:0] t_wd   [2];

   int n_cmp = 0;
   int n_bad = 0;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .ack      (ack),
      .rdata    (rdata),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd)
   );

   always #5 clock = ~clock;

   // Data memory: combinational read, write on the clock edge.
   assign mem_rd = dmem[mem_addr];
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) dmem[i] <= ref_mem[i];
      end else if (mem_we) begin
         dmem[mem_addr] <= mem_wd;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[p]    = r;
      we[p]     = w;
      t_we[p]   = w;
      t_addr[p] = a;
      t_wd[p]   = d;
      if (p == 0) begin
         addr0  = a;
         wdata0 = d;
      end else begin
         addr1  = a;
         wdata1 = d;
      end
   endtask

   task automatic apply_reset();
      req = 2'b00;
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Completed access for port p: rdata must be the pre-access contents.
   task automatic score(input int p);
      check_eq(p == 0 ? "rdata_p0" : "rdata_p1", rdata, ref_mem[t_addr[p]]);
      if (t_we[p]) ref_mem[t_addr[p]] = t_wd[p];
   endtask

   // Raise the enabled ports together, hold each until its ack, check latency.
   task automatic xfer(input logic [1:0] en, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input int exp_lat0, input int exp_lat1);
      logic [1:0] done;
      int lat [2];
      done   = ~en;
      lat[0] = 0;
      lat[1] = 0;
      if (en[0]) drive(0, 1'b1, w[0], a0, d0);
      if (en[1]) drive(1, 1'b1, w[1], a1, d1);
      for (int s = 1; s <= 12 && done != 2'b11; s++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
               check_eq("ack_unexpected", 32'(done[p]), 32'd0);
               if (!done[p]) begin
                  score(p);
                  lat[p]  = s;
                  done[p] = 1'b1;
                  req[p]  = 1'b0;
               end
            end
         end
      end
      check_eq("xfer_complete", 32'(done), 32'd3);
      if (en[0] && exp_lat0 > 0) check_eq("latency_p0", 32'(lat[0]), 32'(exp_lat0));
      if (en[1] && exp_lat1 > 0) check_eq("latency_p1", 32'(lat[1]), 32'(exp_lat1));
      req = 2'b00;
      tick();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(9, 0) == 0) return AW'(1022 + $urandom_range(1, 0));
      return AW'($urandom_range(15, 0));
   endfunction

   // Free-running traffic; a port acked while the other waits must hand over in 2 cycles.
   task automatic run_traffic(input int n_acc, input bit cont,
                              output int cnt0, output int cnt1,
                              output int first_port, output int last_step);
      logic [1:0] pend;
      int age [2];
      int served, step, exp_step, exp_port, acked, writes, we_cycles;
      bit exp_on, abort;
      pend = 2'b00; served = 0; step = 0; exp_on = 1'b0; abort = 1'b0;
      writes = 0; we_cycles = 0; exp_step = 0; exp_port = 0;
      cnt0 = 0; cnt1 = 0; first_port = -1; last_step = 0;
      age[0] = 0; age[1] = 0;
      for (int p = 0; p < 2; p++) begin
         if (cont || $urandom_range(1, 0) == 0) begin
            drive(p, 1'b1, 1'($urandom_range(1, 0)), rand_addr(), $urandom);
            pend[p] = 1'b1;
         end
      end
      while (served < n_acc && !abort) begin
         tick();
         step++;
         if (mem_we) we_cycles++;
         if (ack != 2'b00) check_eq("ack_onehot", 32'(ack == 2'b11), 32'd0);
         if (exp_on && step == exp_step) begin
            check_eq("rr_handover", 32'(ack[exp_port]), 32'd1);
            exp_on = 1'b0;
         end
         acked = -1;
         for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
               check_eq("ack_without_req", 32'(pend[p]), 32'd1);
               if (pend[p]) begin
                  score(p);
                  if (t_we[p]) writes++;
                  pend[p] = 1'b0;
                  served++;
                  if (p == 0) cnt0++; else cnt1++;
                  if (first_port < 0) first_port = p;
                  last_step = step;
                  acked = p;
               end
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               if (served < n_acc && (cont || $urandom_range(2, 0) == 0)) begin
                  drive(p, 1'b1, 1'($urandom_range(1, 0)), rand_addr(), $urandom);
                  pend[p] = 1'b1;
                  age[p]  = 0;
               end else begin
                  req[p] = 1'b0;
               end
            end
         end
         if (acked >= 0 && pend[1-acked]) begin
            exp_on   = 1'b1;
            exp_step = step + 2;
            exp_port = 1 - acked;
         end
         for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
               age[p]++;
               if (age[p] > 6) begin
                  check_eq("ack_timeout", 32'(age[p]), 32'd6);
                  abort = 1'b1;
               end
            end
         end
      end
      req = 2'b00;
      check_eq("write_strobes", 32'(we_cycles), 32'(writes));
      tick();
      tick();
   endtask

   initial begin
      int c0, c1, fp, ls;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      ref_mem[7] = 32'h0000_0000;
      preload = 1'b1;
      tick();
      tick();
      preload = 1'b0;

      check_eq("rst_ack",      32'(ack),      32'd0);
      check_eq("rst_rdata",    rdata,         32'd0);
      check_eq("rst_mem_we",   32'(mem_we),   32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wd",   mem_wd,        32'd0);
      reset = 1'b0;

      // Contention straight out of reset: port 0 first, port 1 with no idle gap.
      xfer(2'b11, 2'b00, AW'(1), AW'(2), 32'd0, 32'd0, 2, 4);

      xfer(2'b01, 2'b01, AW'(5), AW'(0), 32'hDEAD_BEEF, 32'd0, 2, 0);
      xfer(2'b01, 2'b00, AW'(5), AW'(0), 32'd0, 32'd0, 2, 0);

      xfer(2'b10, 2'b10, AW'(0), AW'(1023), 32'd0, 32'h1234_5678, 0, 2);
      xfer(2'b10, 2'b00, AW'(0), AW'(1023), 32'd0, 32'd0, 0, 2);
      xfer(2'b10, 2'b00, AW'(0), AW'(0), 32'd0, 32'd0, 0, 2);
      xfer(2'b01, 2'b00, AW'(1022), AW'(0), 32'd0, 32'd0, 2, 0);

      // Reset lands in the ACCESS cycle of a write; the write must not commit.
      drive(0, 1'b1, 1'b1, AW'(7), 32'hA5A5_A5A5);
      tick();
      check_eq("access_we",   32'(mem_we),   32'd1);
      check_eq("access_addr", 32'(mem_addr), 32'd7);
      #2;
      reset = 1'b1;
      #1;
      check_eq("midrst_ack",      32'(ack),      32'd0);
      check_eq("midrst_mem_we",   32'(mem_we),   32'd0);
      check_eq("midrst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("midrst_mem_wd",   mem_wd,        32'd0);
      check_eq("midrst_rdata",    rdata,         32'd0);
      req = 2'b00;
      tick();
      tick();
      reset = 1'b0;
      xfer(2'b01, 2'b00, AW'(7), AW'(0), 32'd0, 32'd0, 2, 0);

      apply_reset();
      xfer(2'b11, 2'b01, AW'(9), AW'(9), 32'hC0FF_EE09, 32'd0, 2, 4);

      apply_reset();
      run_traffic(8, 1'b1, c0, c1, fp, ls);
      check_eq("cont_cnt_p0",    32'(c0), 32'd4);
      check_eq("cont_cnt_p1",    32'(c1), 32'd4);
      check_eq("cont_first",     32'(fp), 32'd0);
      check_eq("cont_last_step", 32'(ls), 32'd16);

      run_traffic(80, 1'b0, c0, c1, fp, ls);
      check_eq("rand_total", 32'(c0 + c1), 32'd80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
